// File: rtl/phase_seq.sv
// Multi-cycle core phase sequencer: walks PHASES phases per instruction, with memory
// handshakes, run/idle, single-step, halt, ack timeout and a retired-instruction counter.
module phase_seq #(
  parameter int unsigned PHASES      = 5,
  parameter int unsigned FETCH_PHASE = 0,
  parameter int unsigned MEM_PHASE   = 3,
  parameter int unsigned WB_PHASE    = 4,
  parameter int unsigned CNTW        = 32,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      run,
  input  logic                      step_mode,
  input  logic                      step_req,
  input  logic                      halt_in,
  input  logic                      mem_access,
  output logic                      imem_req,
  input  logic                      imem_ack,
  output logic                      dmem_req,
  input  logic                      dmem_ack,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic [PHASES-1:0]         phase_en,
  output logic                      stall,
  output logic                      halted,
  output logic                      timeout_err,
  output logic [CNTW-1:0]           retired
);

  localparam int unsigned PW = $clog2(PHASES);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_STEP_WAIT,
    S_HALT
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   phase_d;
  logic [WW-1:0]   wait_cnt, wait_d;
  logic [CNTW-1:0] retired_d;
  logic            timeout_d;

  logic is_fetch, is_mem, need_ack, ack_seen, done;

  // State register; reset overrides any in-flight handshake
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= S_IDLE;
      phase       <= PW'(FETCH_PHASE);
      wait_cnt    <= '0;
      retired     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      wait_cnt    <= wait_d;
      retired     <= retired_d;
      timeout_err <= timeout_d;
    end
  end

  assign halted = (state == S_HALT);

  // Which handshake (if any) gates completion of the current phase
  always_comb begin
    is_fetch = (state == S_ACTIVE) && (phase == PW'(FETCH_PHASE));
    is_mem   = (state == S_ACTIVE) && (phase == PW'(MEM_PHASE)) && mem_access;
    need_ack = is_fetch || is_mem;
    ack_seen = (is_fetch && imem_ack) || (is_mem && dmem_ack);
    done     = (state == S_ACTIVE) && (!need_ack || ack_seen);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state;
    phase_d   = phase;
    wait_d    = wait_cnt;
    retired_d = retired;
    timeout_d = timeout_err;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    stall     = 1'b0;
    phase_en  = '0;

    case (state)
      S_IDLE: begin
        if (run) begin
          state_d = S_ACTIVE;
          phase_d = PW'(FETCH_PHASE);
        end
      end

      S_ACTIVE: begin
        imem_req = is_fetch;
        dmem_req = is_mem;
        if (done) begin
          phase_en = PHASES'(1) << phase;
          wait_d   = '0;
          if (phase == PW'(WB_PHASE)) begin
            retired_d = retired + CNTW'(1);
            phase_d   = PW'(FETCH_PHASE);
            if (halt_in)        state_d = S_HALT;
            else if (step_mode) state_d = S_STEP_WAIT;
            else if (!run)      state_d = S_IDLE;
          end else begin
            phase_d = phase + PW'(1);
          end
        end else begin
          stall = 1'b1;
          // An ack is still accepted in the cycle where the count has reached TIMEOUT
          if (wait_cnt == WW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
            wait_d    = '0;
          end else begin
            wait_d = wait_cnt + WW'(1);
          end
        end
      end

      S_STEP_WAIT: begin
        if (step_req) begin
          state_d = S_ACTIVE;
          phase_d = PW'(FETCH_PHASE);
        end
      end

      S_HALT: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_seq.sv
// Randomized bench for phase_seq: two instances (CNTW=32 and CNTW=4) share stimulus and are
// compared every cycle against an instruction-level reference model.
module tb_phase_seq;

  localparam int NPH   = 5;
  localparam int TMO   = 15;
  localparam int SEGS  = 60;
  localparam int SEGLEN = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset, run, step_mode, step_req, halt_in, mem_access, imem_ack, dmem_ack;

  logic        a_imem_req, a_dmem_req, a_stall, a_halted, a_terr;
  logic [2:0]  a_phase;
  logic [4:0]  a_phase_en;
  logic [31:0] a_retired;
  logic        b_imem_req, b_dmem_req, b_stall, b_halted, b_terr;
  logic [2:0]  b_phase;
  logic [4:0]  b_phase_en;
  logic [3:0]  b_retired;

  phase_seq u_dut_a (
    .clk(clk), .nreset(nreset), .run(run), .step_mode(step_mode), .step_req(step_req),
    .halt_in(halt_in), .mem_access(mem_access), .imem_req(a_imem_req), .imem_ack(imem_ack),
    .dmem_req(a_dmem_req), .dmem_ack(dmem_ack), .phase(a_phase), .phase_en(a_phase_en),
    .stall(a_stall), .halted(a_halted), .timeout_err(a_terr), .retired(a_retired)
  );

  phase_seq #(.CNTW(4)) u_dut_b (
    .clk(clk), .nreset(nreset), .run(run), .step_mode(step_mode), .step_req(step_req),
    .halt_in(halt_in), .mem_access(mem_access), .imem_req(b_imem_req), .imem_ack(imem_ack),
    .dmem_req(b_dmem_req), .dmem_ack(dmem_ack), .phase(b_phase), .phase_en(b_phase_en),
    .stall(b_stall), .halted(b_halted), .timeout_err(b_terr), .retired(b_retired)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: where the core is in its instruction, not how the RTL encodes it
  bit          running, stepping, stopped, idle;
  int          ph;
  int          waited;
  longint      n_retired;
  bit          tmo_flag;

  task automatic model_reset();
    idle = 1; running = 0; stepping = 0; stopped = 0;
    ph = 0; waited = 0; n_retired = 0; tmo_flag = 0;
  endtask

  // Expected outputs for the current cycle
  bit          e_ireq, e_dreq, e_stall, e_done;
  logic [4:0]  e_en;

  task automatic model_outputs();
    bit ackd;
    e_ireq  = running && ph == 0;
    e_dreq  = running && ph == 3 && mem_access;
    ackd    = e_ireq ? imem_ack : (e_dreq ? dmem_ack : 1'b1);
    e_done  = running && ackd;
    e_stall = running && !ackd;
    e_en    = e_done ? 5'(1 << ph) : 5'd0;
  endtask

  task automatic model_step();
    if (!nreset) begin
      model_reset();
    end else if (idle) begin
      if (run) begin idle = 0; running = 1; ph = 0; end
    end else if (stepping) begin
      if (step_req) begin stepping = 0; running = 1; ph = 0; end
    end else if (running) begin
      if (e_done) begin
        waited = 0;
        if (ph == NPH - 1) begin
          n_retired++;
          ph = 0;
          if (halt_in)        begin running = 0; stopped = 1; end
          else if (step_mode) begin running = 0; stepping = 1; end
          else if (!run)      begin running = 0; idle = 1; end
        end else begin
          ph++;
        end
      end else if (waited == TMO) begin
        running = 0; stopped = 1; tmo_flag = 1; waited = 0;
      end else begin
        waited++;
      end
    end
  endtask

  task automatic compare_all();
    model_outputs();
    check("a_imem_req", 64'(a_imem_req), 64'(e_ireq));
    check("a_dmem_req", 64'(a_dmem_req), 64'(e_dreq));
    check("a_stall",    64'(a_stall),    64'(e_stall));
    check("a_phase_en", 64'(a_phase_en), 64'(e_en));
    check("a_phase",    64'(a_phase),    64'(ph));
    check("a_halted",   64'(a_halted),   64'(stopped));
    check("a_timeout",  64'(a_terr),     64'(tmo_flag));
    check("a_retired",  64'(a_retired),  64'(n_retired & 64'hFFFF_FFFF));
    check("b_phase_en", 64'(b_phase_en), 64'(e_en));
    check("b_retired",  64'(b_retired),  64'(n_retired & 64'hF));
    check("b_halted",   64'(b_halted),   64'(stopped));
  endtask

  int ack_pct, run_pct, halt_pct, step_on;

  initial begin
    nreset = 1'b0; run = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_in = 1'b0;
    mem_access = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int s = 0; s < SEGS; s++) begin
      case ($urandom_range(0, 5))
        0: begin ack_pct = 100; run_pct = 100; halt_pct = 0; step_on = 0; end
        1: begin ack_pct = 40;  run_pct = 95;  halt_pct = 0; step_on = 0; end
        2: begin ack_pct = 100; run_pct = 100; halt_pct = 0; step_on = 1; end
        3: begin ack_pct = 0;   run_pct = 100; halt_pct = 0; step_on = 0; end
        4: begin ack_pct = 60;  run_pct = 70;  halt_pct = 3; step_on = 0; end
        default: begin ack_pct = 15; run_pct = 90; halt_pct = 1; step_on = $urandom_range(0, 1); end
      endcase

      for (int c = 0; c < SEGLEN; c++) begin
        @(negedge clk);
        nreset     = !(c < 2 || ($urandom_range(0, 199) == 0) ||
                       (stopped && $urandom_range(0, 29) == 0));
        run        = ($urandom_range(0, 99) < run_pct);
        step_mode  = step_on[0];
        step_req   = ($urandom_range(0, 11) == 0);
        halt_in    = ($urandom_range(0, 99) < halt_pct);
        mem_access = $urandom_range(0, 1) == 1;
        imem_ack   = ($urandom_range(0, 99) < ack_pct);
        dmem_ack   = ($urandom_range(0, 99) < ack_pct);
        #1;
        compare_all();
        @(posedge clk);
        model_step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
